jedro_1_lsu_master: RTL and testbench
=====================================

Name: jedro_1_lsu_master

Overview:
- Initiator side of the data-memory read/write interface: the load/store unit between the execute stage and the byte-write data RAM.
- Accepts one load or store command at a time.
- Stores: generates byte enables and lane-replicated write data.
- Loads: issues the read, waits the RAM's 1-cycle read latency, then sign- or zero-extends the selected byte/half/word and writes it back to the register file.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.
- REG_ADDR_WIDTH, 5, register-file index width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset. Asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  unit can accept a command.
- cmd_store_i  in  1  1 = store, 0 = load.
- cmd_funct3_i  in  3  RISC-V funct3 (width/sign).
- cmd_addr_i  in  ADDR_WIDTH  byte address (rs1 + imm).
- cmd_wdata_i  in  DATA_WIDTH  store data (rs2).
- cmd_rd_i  in  REG_ADDR_WIDTH  load destination register.
- ram_en_o  out  1  memory access enable.
- ram_we_o  out  4  byte write enables (0000 = read).
- ram_addr_o  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] = 0.
- ram_wdata_o  out  DATA_WIDTH  write data.
- ram_rdata_i  in  DATA_WIDTH  read data, valid one cycle after the read cycle.
- rf_we_o  out  1  writeback strobe, 1-cycle pulse.
- rf_addr_o  out  REG_ADDR_WIDTH  writeback register.
- rf_data_o  out  DATA_WIDTH  extended load result.
- misaligned_o  out  1  1-cycle pulse on a misaligned command.
- illegal_o  out  1  1-cycle pulse on an unsupported funct3.

Behaviour:
- Reset (async, rstn_i low): state IDLE. All outputs 0 except cmd_ready_o = 1. Any in-flight transaction is dropped; no writeback is produced after reset release.
- All outputs are registered.
- FSM states: IDLE, STORE, LD_REQ, LD_WAIT, WB.
- cmd_ready_o = 1 only in IDLE. A command is accepted on a rising edge with cmd_valid_i & cmd_ready_o; address, data, funct3 and rd are latched at that edge.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Store funct3: 000 SB, 001 SH, 010 SW. Any other value, for either type, is illegal.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- Illegal takes precedence over misaligned.
- On an illegal or misaligned command: pulse the flag the cycle after accept, make no memory access, stay in IDLE.
- Store path (IDLE -> STORE -> IDLE): during STORE, ram_en_o = 1.
  - SB: we = 0001 << off; wdata = {4{b}}.
  - SH: we = 0011 << off; wdata = {2{h}}.
  - SW: we = 1111; wdata = w.
  - off = addr[1:0].
- Load path (IDLE -> LD_REQ -> LD_WAIT -> WB -> IDLE):
  - LD_REQ: ram_en_o = 1, we = 0000.
  - LD_WAIT: capture ram_rdata_i.
  - WB: rf_we_o = 1 with the extended result.
  - Byte select: rdata[8*off +: 8]. Half select: rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rd = 0: a load still performs the memory read, but rf_we_o stays 0.
- Timing, with accept on edge E0:
  - Store: write cycle is E0..E1, ready again after E1 (2-cycle occupancy).
  - Load: read cycle E0..E1, rf_we_o high E2..E3, ready again after E3 (4-cycle occupancy).
- ram_en_o, ram_we_o, ram_wdata_o and rf_we_o return to 0 in every cycle not listed above.
- ram_addr_o holds its last value when idle.

Decomposition:
- Shared package (jedro_1_defines):
  - Funct3 constants LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
  - lsu_state_t enum.
  - Byte-enable base constants.
- One sub-module, jedro_1_lsu_extend: combinational lane select and sign/zero extension (inputs rdata, off, funct3).
- FSM, enable generation and store-lane replication stay in the top.

Test Plan:
- RAM word 0 = 0xFFFF000F, LHU addr 2, rd = 30 -> rf_we_o pulse at E2, rf_addr_o = 30, rf_data_o = 0x0000FFFF. Same with LH -> 0xFFFFFFFF.
- Same word, LBU addr 0 rd 14 -> 0x0000000F. LB addr 3 -> 0xFFFFFFFF.
- SH addr 6, wdata 0x1234ABCD -> one cycle with ram_en_o = 1, ram_we_o = 1100, ram_addr_o = 4, ram_wdata_o = 0xABCDABCD. A following LHU addr 6 returns 0x0000ABCD.
- LW addr 5 -> misaligned_o pulse, ram_en_o never asserted, cmd_ready_o stays 1. funct3 = 011 load -> illegal_o pulse, no access.
- Back-to-back commands, cmd_valid_i held high -> accepts spaced exactly 2 cycles (store) or 4 cycles (load); no dropped or duplicated writebacks.
- rstn_i low during LD_WAIT -> all outputs 0 immediately, no rf_we_o after release, first command after release executes normally.

Source files
------------

// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 load/store unit: funct3 encodings,
// byte-enable bases, FSM state type and command classification helpers.
package jedro_1_defines;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_STORE,
    LSU_LD_REQ,
    LSU_LD_WAIT,
    LSU_WB
  } lsu_state_t;

  function automatic logic lsu_illegal(input logic store, input logic [2:0] funct3);
    logic ill;
    if (store) ill = !(funct3 inside {LSU_B, LSU_H, LSU_W});
    else       ill = !(funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
    return ill;
  endfunction

  // funct3[1:0] encodes the access size for every legal load/store.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_extend.sv
// Load result formatting: selects the addressed byte/half lane of a read
// word and sign- or zero-extends it according to funct3.
module jedro_1_lsu_extend
  import jedro_1_defines::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      LSU_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_H:   data_o = {{16{half_sel[15]}}, half_sel};
      LSU_BU:  data_o = {24'b0, byte_sel};
      LSU_HU:  data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu_master.sv
// Load/store unit master: one command at a time towards a byte-write RAM
// with 1-cycle read latency; all outputs are registered.
module jedro_1_lsu_master
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_store_i,
  input  logic [2:0]                cmd_funct3_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_rd_i,
  output logic                      ram_en_o,
  output logic [3:0]                ram_we_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      misaligned_o,
  output logic                      illegal_o
);

  lsu_state_t state_q, state_d;

  logic                      cmd_ready_q, cmd_ready_d;
  logic                      ram_en_q, ram_en_d;
  logic [3:0]                ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;
  logic                      misaligned_q, misaligned_d;
  logic                      illegal_q, illegal_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                off_q, off_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;

  logic                  accept;
  logic                  cmd_ill;
  logic                  cmd_mis;
  logic                  cmd_go;
  logic [3:0]            be_base;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] ext_data;

  assign accept  = cmd_valid_i & cmd_ready_q;
  assign cmd_ill = lsu_illegal(cmd_store_i, cmd_funct3_i);
  assign cmd_mis = lsu_misaligned(cmd_funct3_i, cmd_addr_i[1:0]);
  assign cmd_go  = accept & ~cmd_ill & ~cmd_mis;

  jedro_1_lsu_extend u_extend (
    .rdata_i  (ram_rdata_i),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= LSU_IDLE;
      cmd_ready_q  <= 1'b1;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 4'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      funct3_q     <= 3'b0;
      off_q        <= 2'b0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:    if (cmd_go) state_d = cmd_store_i ? LSU_STORE : LSU_LD_REQ;
      LSU_STORE:   state_d = LSU_IDLE;
      LSU_LD_REQ:  state_d = LSU_LD_WAIT;
      LSU_LD_WAIT: state_d = LSU_WB;
      LSU_WB:      state_d = LSU_IDLE;
      default:     state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    case (cmd_funct3_i[1:0])
      2'b00: begin
        be_base    = BE_BYTE;
        store_data = {4{cmd_wdata_i[7:0]}};
      end
      2'b01: begin
        be_base    = BE_HALF;
        store_data = {2{cmd_wdata_i[15:0]}};
      end
      default: begin
        be_base    = BE_WORD;
        store_data = cmd_wdata_i;
      end
    endcase
  end

  // Registered outputs are computed for the state being entered, so the
  // access and writeback strobes line up with STORE/LD_REQ/WB.
  always_comb begin
    cmd_ready_d  = (state_d == LSU_IDLE);
    ram_en_d     = 1'b0;
    ram_we_d     = 4'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = '0;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    if (accept) begin
      funct3_d     = cmd_funct3_i;
      off_d        = cmd_addr_i[1:0];
      rd_d         = cmd_rd_i;
      illegal_d    = cmd_ill;
      misaligned_d = ~cmd_ill & cmd_mis;
    end
    if (cmd_go) begin
      ram_en_d   = 1'b1;
      ram_addr_d = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
      if (cmd_store_i) begin
        ram_we_d    = be_base << cmd_addr_i[1:0];
        ram_wdata_d = store_data;
      end
    end
    if (state_q == LSU_LD_WAIT) begin
      rf_we_d   = (rd_q != '0);
      rf_addr_d = rd_q;
      rf_data_d = ext_data;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign rf_we_o      = rf_we_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_data_o    = rf_data_q;
  assign misaligned_o = misaligned_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_jedro_1_lsu_master.sv
// Bench for jedro_1_lsu_master: byte-write RAM with 1-cycle read latency, a
// per-cycle expectation schedule built from the access rules, and directed loads/stores.
module tb_jedro_1_lsu_master;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic        cmd_store;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [4:0]  cmd_rd;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        misaligned_o;
  logic        illegal_o;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int free_e = 0;
  int wb_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  longint acc_t[$];

  logic [31:0] ram_mem [16];
  logic [31:0] mdl_mem [16];

  logic        e_en    [N];
  logic [3:0]  e_we    [N];
  logic [31:0] e_wdata [N];
  logic [31:0] e_addr  [N];
  logic        e_rfwe  [N];
  logic [4:0]  e_rfaddr[N];
  logic [31:0] e_rfdata[N];
  logic        e_mis   [N];
  logic        e_ill   [N];
  logic        e_rdy   [N];

  always #5 clk = ~clk;

  jedro_1_lsu_master dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_store_i  (cmd_store),
    .cmd_funct3_i (cmd_funct3),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_rd_i     (cmd_rd),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata),
    .rf_we_o      (rf_we_o),
    .rf_addr_o    (rf_addr_o),
    .rf_data_o    (rf_data_o),
    .misaligned_o (misaligned_o),
    .illegal_o    (illegal_o)
  );

  // RAM driven only by the DUT's memory port.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o == 4'b0000) ram_rdata <= ram_mem[ram_addr_o[5:2]];
      else begin
        for (int b = 0; b < 4; b++)
          if (ram_we_o[b]) ram_mem[ram_addr_o[5:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void clear_slot(input int i);
    if (i < N) begin
      e_en[i] = 1'b0; e_we[i] = 4'b0; e_wdata[i] = 32'h0; e_addr[i] = 32'h0;
      e_rfwe[i] = 1'b0; e_rfaddr[i] = 5'd0; e_rfdata[i] = 32'h0;
      e_mis[i] = 1'b0; e_ill[i] = 1'b0; e_rdy[i] = 1'b1;
    end
  endfunction

  // Model: at every edge decide acceptance and schedule the outputs of the
  // interval following that edge (and of later intervals for loads).
  int          m_e, m_f3, m_off, m_idx, m_sz;
  logic        m_legal, m_mis;
  logic [31:0] m_val, m_a;
  always @(posedge clk) begin
    m_e = edge_n;
    if (!rstn) begin
      for (int k = 0; k < 4; k++) clear_slot(m_e + k);
      free_e = m_e + 1;
      last_addr = 32'h0;
    end else if (cmd_valid && m_e >= free_e && m_e + 3 < N) begin
      m_f3  = int'(cmd_funct3);
      m_a   = cmd_addr;
      m_off = int'(m_a % 4);
      m_idx = int'((m_a / 4) % 16);
      m_sz  = 1 << (m_f3 % 4);
      m_legal = cmd_store ? (m_f3 <= 2) : (m_f3 <= 2 || m_f3 == 4 || m_f3 == 5);
      m_mis = (int'(m_a % 4) % m_sz) != 0;
      if (!m_legal) e_ill[m_e] = 1'b1;
      else if (m_mis) e_mis[m_e] = 1'b1;
      else if (cmd_store) begin
        e_en[m_e]  = 1'b1;
        e_rdy[m_e] = 1'b0;
        e_we[m_e]  = 4'(((1 << m_sz) - 1) << m_off);
        if (m_sz == 1)      e_wdata[m_e] = (cmd_wdata & 32'hFF) * 32'h01010101;
        else if (m_sz == 2) e_wdata[m_e] = (cmd_wdata & 32'hFFFF) * 32'h00010001;
        else                e_wdata[m_e] = cmd_wdata;
        for (int k = 0; k < m_sz; k++)
          mdl_mem[m_idx][8*(m_off+k) +: 8] = cmd_wdata[8*k +: 8];
        last_addr = m_a - 32'(m_off);
        free_e = m_e + 2;
      end else begin
        e_en[m_e] = 1'b1;
        for (int k = 0; k < 3; k++) e_rdy[m_e + k] = 1'b0;
        m_val = mdl_mem[m_idx] >> (8 * m_off);
        if (m_sz == 1) begin
          m_val = m_val & 32'hFF;
          if (m_f3 == 0 && m_val[7]) m_val = m_val | 32'hFFFFFF00;
        end else if (m_sz == 2) begin
          m_val = m_val & 32'hFFFF;
          if (m_f3 == 1 && m_val[15]) m_val = m_val | 32'hFFFF0000;
        end
        e_rfwe[m_e + 2]   = (cmd_rd != 5'd0);
        e_rfaddr[m_e + 2] = cmd_rd;
        e_rfdata[m_e + 2] = m_val;
        last_addr = m_a - 32'(m_off);
        free_e = m_e + 4;
      end
    end
    if (m_e < N) e_addr[m_e] = last_addr;
    edge_n = edge_n + 1;
  end

  always @(posedge clk)
    if (rstn && cmd_valid && cmd_ready_o) acc_t.push_back($time);

  always @(negedge clk)
    if (rf_we_o) wb_cnt++;

  // Per-cycle comparison of every output against the schedule.
  int ci;
  always @(negedge clk) begin
    if (edge_n > 0 && edge_n <= N) begin
      if (!rstn) begin
        chk("rst_en", 32'(ram_en_o), 32'h0);
        chk("rst_we", 32'(ram_we_o), 32'h0);
        chk("rst_addr", ram_addr_o, 32'h0);
        chk("rst_wdata", ram_wdata_o, 32'h0);
        chk("rst_rfwe", 32'(rf_we_o), 32'h0);
        chk("rst_rfaddr", 32'(rf_addr_o), 32'h0);
        chk("rst_rfdata", rf_data_o, 32'h0);
        chk("rst_mis", 32'(misaligned_o), 32'h0);
        chk("rst_ill", 32'(illegal_o), 32'h0);
        chk("rst_ready", 32'(cmd_ready_o), 32'h1);
      end else begin
        ci = edge_n - 1;
        chk("cyc_en", 32'(ram_en_o), 32'(e_en[ci]));
        chk("cyc_we", 32'(ram_we_o), 32'(e_we[ci]));
        chk("cyc_addr", ram_addr_o, e_addr[ci]);
        chk("cyc_wdata", ram_wdata_o, e_wdata[ci]);
        chk("cyc_rfwe", 32'(rf_we_o), 32'(e_rfwe[ci]));
        chk("cyc_mis", 32'(misaligned_o), 32'(e_mis[ci]));
        chk("cyc_ill", 32'(illegal_o), 32'(e_ill[ci]));
        chk("cyc_ready", 32'(cmd_ready_o), 32'(e_rdy[ci]));
        if (e_rfwe[ci]) begin
          chk("cyc_rfaddr", 32'(rf_addr_o), 32'(e_rfaddr[ci]));
          chk("cyc_rfdata", rf_data_o, e_rfdata[ci]);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_store = st; cmd_funct3 = f3; cmd_addr = a; cmd_wdata = wd; cmd_rd = rd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready_o) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    $display("[TB] cmd store=%0d funct3=%03b addr=%h wdata=%h rd=%0d accepted=%0d",
             st, f3, a, wd, rd, ok);
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic expect_wb(input string nm, input logic [4:0] rd, input logic [31:0] data);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rf_we_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({nm, "_wb_timeout"}, 32'h0, 32'h1);
    else begin
      chk({nm, "_rd"}, 32'(rf_addr_o), 32'(rd));
      chk({nm, "_data"}, rf_data_o, data);
    end
  endtask

  task automatic hold(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input int n);
    @(negedge clk);
    cmd_store = st; cmd_funct3 = f3; cmd_addr = a; cmd_wdata = wd; cmd_rd = rd;
    cmd_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 cmd_valid = 1'b0;
    $display("[TB] held store=%0d funct3=%03b addr=%h for %0d edges", st, f3, a, n);
  endtask

  int wb0, a0;

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_funct3 = 3'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_rd = 5'd0;
    ram_rdata = 32'h0;
    for (int i = 0; i < N; i++) clear_slot(i);
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 32'h0;
      mdl_mem[i] = 32'h0;
    end
    ram_mem[0] = 32'hFFFF000F;
    mdl_mem[0] = 32'hFFFF000F;

    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(cmd_ready_o), 32'h1);
    chk("post_reset_en", 32'(ram_en_o), 32'h0);

    issue(1'b0, 3'b101, 32'd2, 32'h0, 5'd30);
    expect_wb("lhu_a2", 5'd30, 32'h0000FFFF);
    issue(1'b0, 3'b001, 32'd2, 32'h0, 5'd30);
    expect_wb("lh_a2", 5'd30, 32'hFFFFFFFF);
    issue(1'b0, 3'b100, 32'd0, 32'h0, 5'd14);
    expect_wb("lbu_a0", 5'd14, 32'h0000000F);
    issue(1'b0, 3'b000, 32'd3, 32'h0, 5'd14);
    expect_wb("lb_a3", 5'd14, 32'hFFFFFFFF);
    issue(1'b0, 3'b010, 32'd0, 32'h0, 5'd1);
    expect_wb("lw_a0", 5'd1, 32'hFFFF000F);

    issue(1'b1, 3'b001, 32'd6, 32'h1234ABCD, 5'd0);
    @(negedge clk);
    chk("sh_en", 32'(ram_en_o), 32'h1);
    chk("sh_we", 32'(ram_we_o), 32'hC);
    chk("sh_addr", ram_addr_o, 32'h4);
    chk("sh_wdata", ram_wdata_o, 32'hABCDABCD);
    @(negedge clk);
    chk("sh_en_after", 32'(ram_en_o), 32'h0);
    issue(1'b0, 3'b101, 32'd6, 32'h0, 5'd7);
    expect_wb("lhu_a6", 5'd7, 32'h0000ABCD);
    issue(1'b0, 3'b001, 32'd6, 32'h0, 5'd7);
    expect_wb("lh_a6", 5'd7, 32'hFFFFABCD);

    issue(1'b1, 3'b000, 32'd9, 32'h0000005A, 5'd0);
    issue(1'b1, 3'b010, 32'd12, 32'hDEADBEEF, 5'd0);
    issue(1'b0, 3'b000, 32'd9, 32'h0, 5'd2);
    expect_wb("lb_a9", 5'd2, 32'h0000005A);
    issue(1'b0, 3'b010, 32'd12, 32'h0, 5'd3);
    expect_wb("lw_a12", 5'd3, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 32'd13, 32'h0, 5'd4);
    expect_wb("lb_a13", 5'd4, 32'hFFFFFFBE);
    issue(1'b0, 3'b100, 32'd13, 32'h0, 5'd4);
    expect_wb("lbu_a13", 5'd4, 32'h000000BE);

    issue(1'b0, 3'b010, 32'd5, 32'h0, 5'd8);
    @(negedge clk);
    chk("lw_mis_flag", 32'(misaligned_o), 32'h1);
    chk("lw_mis_noacc", 32'(ram_en_o), 32'h0);
    chk("lw_mis_ready", 32'(cmd_ready_o), 32'h1);
    issue(1'b1, 3'b001, 32'd3, 32'h5555, 5'd0);
    @(negedge clk);
    chk("sh_mis_flag", 32'(misaligned_o), 32'h1);
    issue(1'b0, 3'b011, 32'd0, 32'h0, 5'd8);
    @(negedge clk);
    chk("ld011_ill", 32'(illegal_o), 32'h1);
    chk("ld011_noacc", 32'(ram_en_o), 32'h0);
    issue(1'b1, 3'b100, 32'd1, 32'h0, 5'd0);
    @(negedge clk);
    chk("st100_ill", 32'(illegal_o), 32'h1);
    chk("st100_not_mis", 32'(misaligned_o), 32'h0);

    wb0 = wb_cnt;
    issue(1'b0, 3'b010, 32'd0, 32'h0, 5'd0);
    repeat (6) @(negedge clk);
    #1 chk("rd0_no_wb", 32'(wb_cnt - wb0), 32'h0);

    a0 = acc_t.size();
    wb0 = wb_cnt;
    hold(1'b0, 3'b010, 32'd12, 32'h0, 5'd5, 12);
    repeat (6) @(negedge clk);
    #1;
    chk("b2b_ld_accepts", 32'(acc_t.size() - a0), 32'd3);
    if (acc_t.size() >= a0 + 2)
      chk("b2b_ld_spacing", 32'(acc_t[a0+1] - acc_t[a0]), 32'd40);
    chk("b2b_ld_wbs", 32'(wb_cnt - wb0), 32'd3);

    a0 = acc_t.size();
    hold(1'b1, 3'b010, 32'd16, 32'h11112222, 5'd0, 6);
    repeat (2) @(negedge clk);
    chk("b2b_st_accepts", 32'(acc_t.size() - a0), 32'd3);
    if (acc_t.size() >= a0 + 2)
      chk("b2b_st_spacing", 32'(acc_t[a0+1] - acc_t[a0]), 32'd20);
    issue(1'b0, 3'b010, 32'd16, 32'h0, 5'd6);
    expect_wb("lw_a16", 5'd6, 32'h11112222);

    issue(1'b0, 3'b010, 32'd12, 32'h0, 5'd9);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_en", 32'(ram_en_o), 32'h0);
    chk("mid_rst_ready", 32'(cmd_ready_o), 32'h1);
    chk("mid_rst_rfwe", 32'(rf_we_o), 32'h0);
    chk("mid_rst_addr", ram_addr_o, 32'h0);
    wb0 = wb_cnt;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("post_rst_no_wb", 32'(wb_cnt - wb0), 32'h0);
    issue(1'b0, 3'b100, 32'd0, 32'h0, 5'd14);
    expect_wb("post_rst_lbu", 5'd14, 32'h0000000F);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
